// File: rtl/aes_enc_kvar_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_pkg                                                                |
// | Shared AES types, constants and index helpers.                         |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Byte (row r, column c) sits at bit 32c+8r of a 128-bit state.
  function automatic int byte_lsb(input int row, input int col);
    return 32 * col + 8 * row;
  endfunction

  function automatic int col_lsb(input int col);
    return 32 * col;
  endfunction

  function automatic int nr_of(input int key_w);
    return key_w / 32 + 6;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_kvar_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_enc_kvar_if                                                        |
// | Block input / ciphertext output handshake bundle of aes_enc_kvar.      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface aes_enc_kvar_if #(
  parameter int KEY_W = 128
);
  logic             data_v_i;
  logic             data_rdy_o;
  logic [127:0]     data_i;
  logic [KEY_W-1:0] key_i;
  logic             res_v_o;
  logic             res_rdy_i;
  logic [127:0]     res_o;
  logic             busy_o;

  modport slave (
    input  data_v_i, data_i, key_i, res_rdy_i,
    output data_rdy_o, res_v_o, res_o, busy_o
  );

  modport master (
    output data_v_i, data_i, key_i, res_rdy_i,
    input  data_rdy_o, res_v_o, res_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_expand4.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_key_expand4                                                        |
// | Generates four expanded key words per step over an NK-word window.     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module aes_key_expand4
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] win_i,   // w[idx-4 .. idx+NK-5]
  input  logic [5:0]       idx_i,   // first word of this round's key
  input  logic [7:0]       rcon_i,
  output logic [32*NK-1:0] win_o,
  output logic [127:0]     rkey_o,  // w[idx .. idx+3]
  output logic [7:0]       rcon_o
);
  logic [32*(NK+4)-1:0] all_w;

  for (genvar k = 0; k < 4; k++) begin : g_word
    logic [6:0]  gidx;
    logic [6:0]  gmod;
    logic        rcon_step;
    logic [31:0] prev_w;
    logic [31:0] sub_in;
    logic [31:0] sub_w;
    logic [31:0] t_w;
    logic [31:0] new_w;

    // The window runs NK-4 words ahead of the round-key index.
    assign gidx      = 7'(idx_i) + 7'(NK - 4 + k);
    assign gmod      = gidx % 7'(NK);
    assign rcon_step = (gmod == 7'd0);

    if (k == 0) begin : g_head
      assign prev_w = win_i[32*(NK-1) +: 32];
    end else begin : g_tail
      assign prev_w = g_word[k-1].new_w;
    end

    assign sub_in = rcon_step ? {prev_w[7:0], prev_w[31:8]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
        .a_i (sub_in[8*b +: 8]),
        .y_o (sub_w[8*b +: 8])
      );
    end

    always_comb begin
      t_w = prev_w;
      if (rcon_step) begin
        t_w = sub_w ^ {24'h0, rcon_i};
      end else if (NK == 8 && gmod == 7'd4) begin
        t_w = sub_w;
      end
    end

    assign new_w = win_i[32*k +: 32] ^ t_w;
  end

  assign all_w  = {g_word[3].new_w, g_word[2].new_w, g_word[1].new_w, g_word[0].new_w, win_i};
  assign rkey_o = all_w[128 +: 128];
  assign win_o  = all_w[32*(NK+4)-1 -: 32*NK];

  // At most one word per step lands on a multiple of NK, so rcon steps once.
  assign rcon_o = (g_word[0].rcon_step | g_word[1].rcon_step |
                   g_word[2].rcon_step | g_word[3].rcon_step) ? xtime(rcon_i) : rcon_i;
endmodule
`default_nettype wire

// File: rtl/aes_mixw.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_mixw                                                               |
// | MixColumns on one 32-bit column (row r at bits 8r+7:8r).               |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module aes_mixw
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_i[7:0];
  assign a1 = col_i[15:8];
  assign a2 = col_i[23:16];
  assign a3 = col_i[31:24];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  assign col_o[7:0]   = x0 ^ x1 ^ a1 ^ a2 ^ a3;
  assign col_o[15:8]  = a0 ^ x1 ^ x2 ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ a1 ^ x2 ^ x3 ^ a3;
  assign col_o[31:24] = x0 ^ a0 ^ a1 ^ a2 ^ x3;
endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_sbox                                                               |
// | Forward AES S-box, one byte, table lookup.                             |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  // Entry 0 is the most significant byte, hence the inverted index.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX_TABLE[{~a_i, 3'b000} +: 8];
endmodule
`default_nettype wire

// File: rtl/aes_enc_kvar.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_enc_kvar                                                           |
// | Iterative AES-128/192/256 encryptor, one round per clock.              |
// | Option macro: AES_ENC_KVAR_ABORT_EN adds the abort_i port.             |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module aes_enc_kvar
  import aes_pkg::*;
#(
  parameter int KEY_W = 128
) (
  input  logic          clk,
  input  logic          nreset,
`ifdef AES_ENC_KVAR_ABORT_EN
  input  logic          abort_i,
`endif
  aes_enc_kvar_if.slave bus
);
  localparam int NK = KEY_W / 32;
  localparam int NR = nr_of(KEY_W);

  if (KEY_W != 128 && KEY_W != 192 && KEY_W != 256) begin : g_bad_key_w
    $error("aes_enc_kvar: KEY_W must be 128, 192 or 256");
  end

  aes_state_e       state_q, state_d;
  logic [127:0]     blk_q, blk_d;
  logic [KEY_W-1:0] win_q, win_d;
  logic [5:0]       idx_q, idx_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [127:0]     res_q, res_d;
  logic             res_v_q, res_v_d;
  logic             busy_q, busy_d;

  logic [127:0]     sb, sr, mc, nxt_blk, rkey;
  logic [KEY_W-1:0] kx_win;
  logic [7:0]       kx_rcon;
  logic             last_rnd;
  logic             abort;
  logic             data_rdy;
  logic             accept;

`ifdef AES_ENC_KVAR_ABORT_EN
  assign abort = abort_i & (state_q != ST_IDLE);
`else
  assign abort = 1'b0;
`endif

  for (genvar b = 0; b < 16; b++) begin : g_subbytes
    aes_sbox u_sbox (
      .a_i (blk_q[8*b +: 8]),
      .y_o (sb[8*b +: 8])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[byte_lsb(r, c) +: 8] = sb[byte_lsb(r, (c + r) % 4) +: 8];
    end
    aes_mixw u_mixw (
      .col_i (sr[col_lsb(c) +: 32]),
      .col_o (mc[col_lsb(c) +: 32])
    );
  end

  aes_key_expand4 #(.NK(NK)) u_key_expand4 (
    .win_i  (win_q),
    .idx_i  (idx_q),
    .rcon_i (rcon_q),
    .win_o  (kx_win),
    .rkey_o (rkey),
    .rcon_o (kx_rcon)
  );

  assign last_rnd = (rnd_q == 4'(NR));
  assign nxt_blk  = (last_rnd ? sr : mc) ^ rkey;

  // Abort wins over a same-cycle accept from DONE.
  assign data_rdy = (state_q == ST_IDLE) |
                    ((state_q == ST_DONE) & bus.res_rdy_i & ~abort);
  assign accept   = data_rdy & bus.data_v_i;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    win_d   = win_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    res_d   = res_q;
    res_v_d = res_v_q;
    busy_d  = busy_q;

    if (state_q == ST_ROUND) begin
      blk_d  = nxt_blk;
      win_d  = kx_win;
      idx_d  = idx_q + 6'd4;
      rcon_d = kx_rcon;
      rnd_d  = rnd_q + 4'd1;
      if (last_rnd) begin
        state_d = ST_DONE;
        res_d   = nxt_blk;
        res_v_d = 1'b1;
        busy_d  = 1'b0;
      end
    end else if (state_q == ST_DONE && bus.res_rdy_i) begin
      state_d = ST_IDLE;
      res_v_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      state_d = (state_q == ST_DONE) ? ST_DONE : ST_IDLE;
    end

    if (accept) begin
      state_d = ST_ROUND;
      blk_d   = bus.data_i ^ bus.key_i[127:0];
      win_d   = bus.key_i;
      idx_d   = 6'd4;
      rcon_d  = RCON_INIT;
      rnd_d   = 4'd1;
      res_v_d = 1'b0;
      busy_d  = 1'b1;
    end

    if (abort) begin
      state_d = ST_IDLE;
      res_d   = '0;
      res_v_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= '0;
      rnd_q   <= '0;
      res_q   <= '0;
      res_v_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      res_q   <= res_d;
      res_v_q <= res_v_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data_rdy_o = data_rdy;
  assign bus.res_v_o    = res_v_q;
  assign bus.res_o      = res_q;
  assign bus.busy_o     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_enc_kvar.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_aes_enc_kvar                                                        |
// | Directed FIPS-197 vectors on AES-128/192/256 instances.                |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_aes_enc_kvar;
  logic         clk = 1'b0;
  logic         nreset;
  logic         dv [3];
  logic         rr [3];
  logic [255:0] key;
  logic [127:0] pt;
  logic         res_v [3];
  logic         rdy [3];
  logic         busy [3];
  logic [127:0] res [3];
`ifdef AES_ENC_KVAR_ABORT_EN
  logic         abort [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int seen;
  logic [127:0] hold;
  logic [127:0] pt_c, appb_key, appb_pt, appb_ct;
  logic [127:0] ct_tab [3];
  int           nr_tab [3];

  always #5 clk = ~clk;

  aes_enc_kvar_if #(.KEY_W(128)) if128 ();
  aes_enc_kvar_if #(.KEY_W(192)) if192 ();
  aes_enc_kvar_if #(.KEY_W(256)) if256 ();

  assign if128.data_v_i = dv[0];
  assign if192.data_v_i = dv[1];
  assign if256.data_v_i = dv[2];
  assign if128.res_rdy_i = rr[0];
  assign if192.res_rdy_i = rr[1];
  assign if256.res_rdy_i = rr[2];
  assign if128.data_i = pt;
  assign if192.data_i = pt;
  assign if256.data_i = pt;
  assign if128.key_i = key[127:0];
  assign if192.key_i = key[191:0];
  assign if256.key_i = key;
  assign res_v[0] = if128.res_v_o;
  assign res_v[1] = if192.res_v_o;
  assign res_v[2] = if256.res_v_o;
  assign rdy[0] = if128.data_rdy_o;
  assign rdy[1] = if192.data_rdy_o;
  assign rdy[2] = if256.data_rdy_o;
  assign busy[0] = if128.busy_o;
  assign busy[1] = if192.busy_o;
  assign busy[2] = if256.busy_o;
  assign res[0] = if128.res_o;
  assign res[1] = if192.res_o;
  assign res[2] = if256.res_o;

  aes_enc_kvar #(.KEY_W(128)) u_dut128 (
    .clk     (clk),
    .nreset  (nreset),
`ifdef AES_ENC_KVAR_ABORT_EN
    .abort_i (abort[0]),
`endif
    .bus     (if128)
  );

  aes_enc_kvar #(.KEY_W(192)) u_dut192 (
    .clk     (clk),
    .nreset  (nreset),
`ifdef AES_ENC_KVAR_ABORT_EN
    .abort_i (abort[1]),
`endif
    .bus     (if192)
  );

  aes_enc_kvar #(.KEY_W(256)) u_dut256 (
    .clk     (clk),
    .nreset  (nreset),
`ifdef AES_ENC_KVAR_ABORT_EN
    .abort_i (abort[2]),
`endif
    .bus     (if256)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hex strings in FIPS-197 list byte 0 first; byte 0 lives at bits 7:0 here.
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int b = 0; b < 16; b++) y[8*b +: 8] = x[8*(15-b) +: 8];
    return y;
  endfunction

  function automatic logic [255:0] seq_key(input int nbytes);
    logic [255:0] k;
    k = '0;
    for (int b = 0; b < nbytes; b++) k[8*b +: 8] = 8'(b);
    return k;
  endfunction

  task automatic send(input int s, input logic [255:0] k, input logic [127:0] p);
    key   = k;
    pt    = p;
    dv[s] = 1'b1;
    @(posedge clk);
    #1;
    dv[s] = 1'b0;
  endtask

  task automatic wait_res(input int s, output int l);
    l = 0;
    while (!res_v[s] && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic drain(input int s);
    rr[s] = 1'b1;
    @(posedge clk);
    #1;
    rr[s] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_c      = bswap(128'h00112233445566778899aabbccddeeff);
    ct_tab[0] = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ct_tab[1] = bswap(128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    ct_tab[2] = bswap(128'h8ea2b7ca516745bfeafc49904b496089);
    appb_key  = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
    appb_pt   = bswap(128'h3243f6a8885a308d313198a2e0370734);
    appb_ct   = bswap(128'h3925841d02dc09fbdc118597196a0b32);
    nr_tab    = '{10, 12, 14};

    for (int s = 0; s < 3; s++) begin
      dv[s] = 1'b0;
      rr[s] = 1'b0;
`ifdef AES_ENC_KVAR_ABORT_EN
      abort[s] = 1'b0;
`endif
    end
    key    = '0;
    pt     = '0;
    nreset = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_val($sformatf("reset_res_v_%0d", s), res_v[s], 1'b0);
      check_val($sformatf("reset_busy_%0d", s), busy[s], 1'b0);
      check_val($sformatf("reset_res_%0d", s), res[s], 128'h0);
      check_val($sformatf("reset_rdy_%0d", s), rdy[s], 1'b1);
    end
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1 / C.2 / C.3
    for (int s = 0; s < 3; s++) begin
      send(s, seq_key(16 + 8 * s), pt_c);
      check_val($sformatf("busy_after_accept_%0d", s), busy[s], 1'b1);
      check_val($sformatf("rdy_in_round_%0d", s), rdy[s], 1'b0);
      wait_res(s, lat);
      check_val($sformatf("latency_%0d", s), lat, nr_tab[s]);
      check_val($sformatf("ct_fips_%0d", s), res[s], ct_tab[s]);
      drain(s);
      check_val($sformatf("res_v_after_drain_%0d", s), res_v[s], 1'b0);
      check_val($sformatf("rdy_after_drain_%0d", s), rdy[s], 1'b1);
    end

    // Backpressure, then accept the next block in the same cycle as the drain
    send(0, seq_key(16), pt_c);
    wait_res(0, lat);
    check_val("bp_first_ct", res[0], ct_tab[0]);
    hold = res[0];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("bp_hold_res_%0d", c), res[0], hold);
      check_val($sformatf("bp_hold_v_%0d", c), res_v[0], 1'b1);
      check_val($sformatf("bp_rdy_low_%0d", c), rdy[0], 1'b0);
    end
    key   = {128'h0, appb_key};
    pt    = appb_pt;
    dv[0] = 1'b1;
    rr[0] = 1'b1;
    #1;
    check_val("b2b_rdy", rdy[0], 1'b1);
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    rr[0] = 1'b0;
    check_val("b2b_res_v_drop", res_v[0], 1'b0);
    check_val("b2b_busy", busy[0], 1'b1);
    wait_res(0, lat);
    check_val("b2b_latency", lat, 10);
    check_val("b2b_ct", res[0], appb_ct);
    drain(0);

    // Asynchronous reset in round 5 of an AES-192 block
    send(1, seq_key(24), pt_c);
    repeat (4) @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    check_val("rst_mid_busy", busy[1], 1'b0);
    check_val("rst_mid_res_v", res_v[1], 1'b0);
    check_val("rst_mid_rdy", rdy[1], 1'b1);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (res_v[1]) seen++;
    end
    check_val("rst_no_result", seen, 0);
    send(1, seq_key(24), pt_c);
    wait_res(1, lat);
    check_val("rst_next_latency", lat, 12);
    check_val("rst_next_ct", res[1], ct_tab[1]);
    drain(1);

`ifdef AES_ENC_KVAR_ABORT_EN
    // Abort in round 3
    send(0, seq_key(16), pt_c);
    repeat (2) @(posedge clk);
    #1;
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    check_val("abort_busy", busy[0], 1'b0);
    check_val("abort_res_v", res_v[0], 1'b0);
    check_val("abort_idle_rdy", rdy[0], 1'b1);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (res_v[0]) seen++;
    end
    check_val("abort_no_result", seen, 0);

    // Abort on the completion edge
    send(0, seq_key(16), pt_c);
    repeat (9) @(posedge clk);
    #1;
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    check_val("abort_last_res_v", res_v[0], 1'b0);
    check_val("abort_last_res", res[0], 128'h0);
    check_val("abort_last_busy", busy[0], 1'b0);

    // Abort while idle does not block an accept
    abort[0] = 1'b1;
    send(0, seq_key(16), pt_c);
    abort[0] = 1'b0;
    check_val("abort_idle_accept", busy[0], 1'b1);
    wait_res(0, lat);
    check_val("abort_idle_latency", lat, 10);
    check_val("abort_idle_ct", res[0], ct_tab[0]);
    drain(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
